// File: rtl/hs_pkg.sv
// Shared constants, helpers and state encoding for the valid/ready handshake stages.
package hs_pkg;

    localparam int HS_WIDTH = 32;
    localparam int HS_BYTE  = 8;

    // One-bit state encoding shared by the handshake stages: the busy flag.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    function automatic int hs_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic int hs_cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/hs_slice_mux.sv
// Selects one OUT_WIDTH slice of a wide word by index, MSB-first or LSB-first.
module hs_slice_mux
    import hs_pkg::*;
#(
    parameter int IN_WIDTH  = HS_WIDTH,
    parameter int OUT_WIDTH = HS_BYTE,
    parameter bit MSB_FIRST = 1'b1,
    parameter int RATIO     = hs_ratio(IN_WIDTH, OUT_WIDTH),
    parameter int CNT_W     = hs_cnt_width(RATIO)
) (
    input  logic [IN_WIDTH-1:0]  word,
    input  logic [CNT_W-1:0]     sel,
    input  logic                 en,
    output logic [OUT_WIDTH-1:0] slice
);

    // Disabled selection yields zero so an idle output bus stays quiet.
    always_comb begin
        slice = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (en && (sel == CNT_W'(k))) begin
                if (MSB_FIRST) begin
                    slice = word[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
                end else begin
                    slice = word[k*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/hs_downsizer.sv
// Valid/ready width down-converter: one wide word in, RATIO narrow beats out, last beat flagged.
module hs_downsizer
    import hs_pkg::*;
#(
    parameter int IN_WIDTH  = HS_WIDTH,
    parameter int OUT_WIDTH = HS_BYTE,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [15:0]          words_done
);

    localparam int RATIO = hs_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W = hs_cnt_width(RATIO);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("hs_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
        end
    endgenerate

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic [15:0]         words_done_q, words_done_d;

    logic busy;
    logic at_last;
    logic last_acc;
    logic load;

    // in_ready only sees out_ready through last_acc; in_valid never reaches out_*.
    always_comb begin
        busy     = (state_q == ST_SEND);
        at_last  = (beat_cnt_q == LAST_BEAT);
        last_acc = busy & out_ready & at_last;
        in_ready = ~busy | last_acc;
        load     = in_valid & in_ready;

        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        hold_d       = hold_q;
        words_done_d = words_done_q + 16'(last_acc);

        if (load) begin
            hold_d     = in_data;
            beat_cnt_d = '0;
            state_d    = ST_SEND;
        end else if (last_acc) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
        end else if (busy && out_ready) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            hold_q       <= '0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            hold_q       <= hold_d;
            words_done_q <= words_done_d;
        end
    end

    hs_slice_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .RATIO     (RATIO),
        .CNT_W     (CNT_W)
    ) u_slice_mux (
        .word  (hold_q),
        .sel   (beat_cnt_q),
        .en    (busy),
        .slice (out_data)
    );

    always_comb begin
        out_valid  = busy;
        out_last   = busy & at_last;
        words_done = words_done_q;
    end

endmodule

// File: tb/tb_hs_downsizer.sv
// Bench for hs_downsizer: MSB-first and LSB-first builds side by side, checked against a beat-queue model.
module tb_hs_downsizer;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int R  = IW / OW;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          m_in_ready, m_out_valid, m_out_last;
    logic [OW-1:0] m_out_data;
    logic [15:0]   m_words_done;
    logic          l_in_ready, l_out_valid, l_out_last;
    logic [OW-1:0] l_out_data;
    logic [15:0]   l_words_done;

    int vectors = 0;
    int miscompares = 0;

    beat_t qm[$];
    beat_t ql[$];
    int          model_last_cnt = 0;
    logic [15:0] wd_offset = '0;

    always #5 clk = ~clk;

    hs_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (m_in_ready),
        .in_data    (in_data),
        .out_valid  (m_out_valid),
        .out_ready  (out_ready),
        .out_data   (m_out_data),
        .out_last   (m_out_last),
        .words_done (m_words_done)
    );

    hs_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (l_in_ready),
        .in_data    (in_data),
        .out_valid  (l_out_valid),
        .out_ready  (out_ready),
        .out_data   (l_out_data),
        .out_last   (l_out_last),
        .words_done (l_words_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [IW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBeat(input string name, input logic [OW-1:0] exp_m,
                             input logic [OW-1:0] exp_l, input logic exp_last);
        checkOutput({name, "_m_valid"}, 32'(m_out_valid), 32'd1);
        checkOutput({name, "_m_data"},  32'(m_out_data),  32'(exp_m));
        checkOutput({name, "_m_last"},  32'(m_out_last),  32'(exp_last));
        checkOutput({name, "_l_valid"}, 32'(l_out_valid), 32'd1);
        checkOutput({name, "_l_data"},  32'(l_out_data),  32'(exp_l));
        checkOutput({name, "_l_last"},  32'(l_out_last),  32'(exp_last));
    endtask

    task automatic checkIdle(input string name, input logic [15:0] exp_wd);
        checkOutput({name, "_m_valid"}, 32'(m_out_valid),  32'd0);
        checkOutput({name, "_m_data"},  32'(m_out_data),   32'd0);
        checkOutput({name, "_m_last"},  32'(m_out_last),   32'd0);
        checkOutput({name, "_m_ready"}, 32'(m_in_ready),   32'd1);
        checkOutput({name, "_m_wd"},    32'(m_words_done), 32'(exp_wd));
        checkOutput({name, "_l_valid"}, 32'(l_out_valid),  32'd0);
        checkOutput({name, "_l_ready"}, 32'(l_in_ready),   32'd1);
        checkOutput({name, "_l_wd"},    32'(l_words_done), 32'(exp_wd));
    endtask

    // Model: a word becomes R queued beats; a beat leaves whenever the queue is non-empty and out_ready is high.
    initial begin
        logic take_in;
        beat_t b;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                qm.delete();
                ql.delete();
                model_last_cnt = 0;
            end else begin
                take_in = in_valid && ((qm.size() == 0) || (qm.size() == 1 && out_ready));
                if (qm.size() > 0 && out_ready) begin
                    if (qm[0].last) model_last_cnt++;
                    void'(qm.pop_front());
                    void'(ql.pop_front());
                end
                if (take_in) begin
                    for (int k = 0; k < R; k++) begin
                        b.last = (k == R - 1);
                        b.data = OW'(in_data >> (IW - OW * (k + 1)));
                        qm.push_back(b);
                        b.data = OW'(in_data >> (OW * k));
                        ql.push_back(b);
                    end
                end
            end
        end
    end

    // Every cycle out of reset, both builds must match the model's view of the beat queues.
    initial begin
        logic          ev;
        logic [OW-1:0] ed_m, ed_l;
        logic          el;
        logic          er;
        logic [15:0]   ew;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ev   = (qm.size() != 0);
                ed_m = ev ? qm[0].data : '0;
                ed_l = ev ? ql[0].data : '0;
                el   = ev ? qm[0].last : 1'b0;
                er   = (qm.size() == 0) || (qm.size() == 1 && out_ready);
                ew   = 16'(model_last_cnt) + wd_offset;
                checkOutput("cmp_m_valid", 32'(m_out_valid),  32'(ev));
                checkOutput("cmp_m_data",  32'(m_out_data),   32'(ed_m));
                checkOutput("cmp_m_last",  32'(m_out_last),   32'(el));
                checkOutput("cmp_m_ready", 32'(m_in_ready),   32'(er));
                checkOutput("cmp_m_wd",    32'(m_words_done), 32'(ew));
                checkOutput("cmp_l_valid", 32'(l_out_valid),  32'(ev));
                checkOutput("cmp_l_data",  32'(l_out_data),   32'(ed_l));
                checkOutput("cmp_l_last",  32'(l_out_last),   32'(el));
                checkOutput("cmp_l_ready", 32'(l_in_ready),   32'(er));
                checkOutput("cmp_l_wd",    32'(l_words_done), 32'(ew));
            end
        end
    end

    initial begin
        logic [OW-1:0] m1 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        logic [OW-1:0] l1 [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        logic [OW-1:0] m2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic [OW-1:0] l2 [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        logic          r2 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [OW-1:0] m5 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [OW-1:0] l5 [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checkIdle("reset", 16'd0);

        $display("[TB] single word, out_ready held high");
        applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
        checkOutput("t1_accept_ready", 32'(m_in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkBeat("t1_beat", m1[i], l1[i], i == 3);
            tick();
        end
        checkIdle("t1_done", 16'd1);

        $display("[TB] back-to-back words");
        applyStimulus(1'b1, 32'h11223344, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h55667788, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) applyStimulus(1'b0, '0, 1'b1);
            checkBeat("t2_beat", m2[i], l2[i], (i == 3) || (i == 7));
            if (i < 7) checkOutput("t2_in_ready", 32'(m_in_ready), 32'(r2[i]));
            tick();
        end
        checkIdle("t2_done", 16'd3);

        $display("[TB] backpressure on second beat");
        applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkBeat("t3_beat0", m1[0], l1[0], 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            checkBeat("t3_hold", m1[1], l1[1], 1'b0);
            checkOutput("t3_hold_ready", 32'(m_in_ready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            checkBeat("t3_beat", m1[i], l1[i], i == 3);
            if (i < 3) checkOutput("t3_in_ready", 32'(m_in_ready), 32'd0);
            tick();
        end
        checkIdle("t3_done", 16'd4);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        tick();
        checkBeat("t5_pre", m1[2], l1[2], 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_rst_m_valid", 32'(m_out_valid), 32'd0);
        checkOutput("t5_rst_m_ready", 32'(m_in_ready),  32'd1);
        checkOutput("t5_rst_m_data",  32'(m_out_data),  32'd0);
        checkOutput("t5_rst_l_valid", 32'(l_out_valid), 32'd0);
        checkOutput("t5_rst_l_ready", 32'(l_in_ready),  32'd1);
        tick();
        rst = 1'b0;
        checkIdle("t5_released", 16'd0);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkBeat("t5_beat", m5[i], l5[i], i == 3);
            tick();
        end
        checkIdle("t5_done", 16'd1);

        $display("[TB] words_done wrap");
        wd_offset = 16'hFFFF - 16'(model_last_cnt);
        force dut_msb.words_done_q = 16'hFFFF;
        force dut_lsb.words_done_q = 16'hFFFF;
        #1;
        release dut_msb.words_done_q;
        release dut_lsb.words_done_q;
        checkOutput("t6_preload", 32'(m_words_done), 32'h0000FFFF);
        applyStimulus(1'b1, 32'h01020304, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        repeat (4) tick();
        checkIdle("t6_wrapped", 16'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
